match_controller: RTL and testbench

- Downstream consumer of the ball controller's score events.
- Turns the toggle-encoded blue_score_up / red_score_up into score counts.
- Sequences the match: idle, serve, play, over. Drives game_initiated / game_over back to the ball controller.
- Exports scores and winner to the scoreboard/VGA overlay.

---
 rtl/match_pkg.sv | 25 ++
 rtl/sync_rise_detect.sv | 31 +++
 rtl/match_controller.sv | 150 +++++++++++++++
 tb/tb_match_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types for the match sequencer: FSM states and winner encoding.
package match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        SERVE = 2'd2,
        OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_BLUE = 2'b01,
        WIN_RED  = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    function automatic winner_t win_code(input logic blue_win, input logic red_win);
        win_code = WIN_NONE;
        if (blue_win && red_win) win_code = WIN_DRAW;
        else if (blue_win)       win_code = WIN_BLUE;
        else if (red_win)        win_code = WIN_RED;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous level input, followed by a
// registered one-cycle pulse on each synchronized rising edge.
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/match_controller.sv
// Match sequencer: counts toggle-encoded goals, runs the serve delay and
// decides the winner for the scoreboard overlay.
//
// state | meaning
// IDLE  | waiting for the first start press, ball dead
// PLAY  | ball alive, goals counted
// SERVE | ball dead at centre for SERVE_DELAY cycles, late goals still counted
// OVER  | a team reached WIN_SCORE, scores and winner frozen
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int SERVE_DELAY = 50000000,
    parameter int SCORE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_btn,
    input  logic                   blue_score_up,
    input  logic                   red_score_up,
    output logic                   game_initiated,
    output logic                   game_over,
    output logic [SCORE_WIDTH-1:0] blue_score,
    output logic [SCORE_WIDTH-1:0] red_score,
    output logic [1:0]             winner,
    output logic                   goal_pulse
);

    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0]       SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] ONE        = SCORE_WIDTH'(1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_serve_cnt;
    logic                   r_armed;
    logic                   r_blue_hist;
    logic                   r_red_hist;
    logic                   r_game_initiated;
    logic                   r_game_over;
    logic [SCORE_WIDTH-1:0] r_blue_score;
    logic [SCORE_WIDTH-1:0] r_red_score;
    winner_t                r_winner;
    logic                   r_goal_pulse;

    logic                   w_start_rise;
    logic                   w_counting;
    logic                   w_blue_cnt;
    logic                   w_red_cnt;
    logic                   w_any_goal;
    logic [SCORE_WIDTH-1:0] w_blue_next;
    logic [SCORE_WIDTH-1:0] w_red_next;
    logic                   w_blue_win;
    logic                   w_red_win;
    logic                   w_win_any;

    sync_rise_detect u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (start_btn),
        .o_rise  (w_start_rise)
    );

    // Toggles changing in IDLE/OVER still move the history, so they are absorbed.
    assign w_counting  = (r_state == PLAY) || (r_state == SERVE);
    assign w_blue_cnt  = w_counting & r_armed & (blue_score_up ^ r_blue_hist);
    assign w_red_cnt   = w_counting & r_armed & (red_score_up ^ r_red_hist);
    assign w_any_goal  = w_blue_cnt | w_red_cnt;

    assign w_blue_next = (w_blue_cnt && (r_blue_score < WIN_VAL)) ? r_blue_score + ONE : r_blue_score;
    assign w_red_next  = (w_red_cnt && (r_red_score < WIN_VAL)) ? r_red_score + ONE : r_red_score;
    assign w_blue_win  = w_blue_cnt && (w_blue_next == WIN_VAL);
    assign w_red_win   = w_red_cnt && (w_red_next == WIN_VAL);
    assign w_win_any   = w_blue_win | w_red_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_serve_cnt      <= '0;
            r_armed          <= 1'b0;
            r_blue_hist      <= 1'b0;
            r_red_hist       <= 1'b0;
            r_game_initiated <= 1'b0;
            r_game_over      <= 1'b0;
            r_blue_score     <= '0;
            r_red_score      <= '0;
            r_winner         <= WIN_NONE;
            r_goal_pulse     <= 1'b0;
        end else begin
            // Ball controller toggles have no reset, so the first edge only captures them.
            r_armed      <= 1'b1;
            r_blue_hist  <= blue_score_up;
            r_red_hist   <= red_score_up;
            r_goal_pulse <= w_any_goal;

            case (r_state)
                IDLE: begin
                    if (w_start_rise) begin
                        r_state          <= PLAY;
                        r_game_initiated <= 1'b1;
                    end
                end
                PLAY, SERVE: begin
                    r_blue_score <= w_blue_next;
                    r_red_score  <= w_red_next;
                    if (w_win_any) begin
                        r_state          <= OVER;
                        r_game_initiated <= 1'b0;
                        r_game_over      <= 1'b1;
                        r_winner         <= win_code(w_blue_win, w_red_win);
                    end else if (w_any_goal) begin
                        r_state          <= SERVE;
                        r_game_initiated <= 1'b0;
                        r_serve_cnt      <= SERVE_LOAD;
                    end else if (r_state == SERVE) begin
                        if (r_serve_cnt == '0) begin
                            r_state          <= PLAY;
                            r_game_initiated <= 1'b1;
                        end else begin
                            r_serve_cnt <= r_serve_cnt - 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (w_start_rise) begin
                        r_state      <= SERVE;
                        r_game_over  <= 1'b0;
                        r_blue_score <= '0;
                        r_red_score  <= '0;
                        r_winner     <= WIN_NONE;
                        r_serve_cnt  <= SERVE_LOAD;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_game_initiated <= 1'b0;
                    r_game_over      <= 1'b0;
                end
            endcase
        end
    end

    assign game_initiated = r_game_initiated;
    assign game_over      = r_game_over;
    assign blue_score     = r_blue_score;
    assign red_score      = r_red_score;
    assign winner         = r_winner;
    assign goal_pulse     = r_goal_pulse;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: goal events are checked by a
// scoreboard monitor, sequencing and timing by direct checks.
module tb_match_controller;

    localparam int WIN_SCORE   = 3;
    localparam int SERVE_DELAY = 8;
    localparam int SCORE_WIDTH = 4;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       blue_up;
    logic       red_up;
    logic       game_initiated;
    logic       game_over;
    logic [3:0] blue_score;
    logic [3:0] red_score;
    logic [1:0] winner;
    logic       goal_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] sb_q[$];
    logic [11:0] mon_exp;

    match_controller #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_DELAY (SERVE_DELAY),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_btn      (start_btn),
        .blue_score_up  (blue_up),
        .red_score_up   (red_up),
        .game_initiated (game_initiated),
        .game_over      (game_over),
        .blue_score     (blue_score),
        .red_score      (red_score),
        .winner         (winner),
        .goal_pulse     (goal_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pack_exp(int b, int r, int w, int ov, int gi);
        pack_exp = {4'(b), 4'(r), 2'(w), 1'(ov), 1'(gi)};
    endfunction

    function automatic logic [11:0] pack_act();
        pack_act = {blue_score, red_score, winner, game_over, game_initiated};
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every goal_pulse must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (goal_pulse === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_goal_pulse: got pulse with state 0x%0h, expected no pulse", pack_act());
            end else begin
                mon_exp = sb_q.pop_front();
                check("goal_event", 32'(pack_act()), 32'(mon_exp));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goal(bit b, bit r, logic [11:0] exp);
        sb_q.push_back(exp);
        if (b) blue_up = ~blue_up;
        if (r) red_up = ~red_up;
        tick(1);
    endtask

    task automatic wait_play(string name);
        int c;
        c = 0;
        while (game_initiated !== 1'b1 && c < 40) begin
            tick(1);
            c++;
        end
        check(name, 32'(game_initiated), 32'd1);
    endtask

    // Counts consecutive cycles with the ball dead, starting at the current sample.
    task automatic serve_len(string name, bit poke_start);
        int c;
        c = 0;
        while (game_initiated === 1'b0 && c < 30) begin
            c++;
            if (poke_start && c == 1) start_btn = 1'b0;
            if (poke_start && c == 3) start_btn = 1'b1;
            tick(1);
        end
        check(name, 32'(c), 32'(SERVE_DELAY));
    endtask

    task automatic wait_over_clear(string name);
        int c;
        c = 0;
        while (game_over !== 1'b0 && c < 20) begin
            tick(1);
            c++;
        end
        check(name, 32'(game_over), 32'd0);
    endtask

    initial begin
        int c;
        rst_n     = 1'b0;
        start_btn = 1'b0;
        blue_up   = 1'b1;
        red_up    = 1'b0;

        tick(2);
        check("reset_outputs", 32'({pack_act(), goal_pulse}), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("arm_blue_score", 32'(blue_score), 32'd0);
        check("arm_idle", 32'({game_initiated, game_over}), 32'd0);

        start_btn = 1'b1;
        c = 0;
        while (game_initiated !== 1'b1 && c < 20) begin
            tick(1);
            c++;
        end
        check("start_latency", 32'(c), 32'd4);
        start_btn = 1'b0;
        tick(3);

        goal(0, 1, pack_exp(0, 1, 0, 0, 0));
        serve_len("serve_after_red", 1'b0);
        check("play_after_serve", 32'({game_initiated, game_over}), 32'b10);

        goal(1, 0, pack_exp(1, 1, 0, 0, 0));
        wait_play("play_b1");
        goal(1, 0, pack_exp(2, 1, 0, 0, 0));
        wait_play("play_b2");
        goal(1, 0, pack_exp(3, 1, 1, 1, 0));
        tick(2);
        check("blue_win_state", 32'(pack_act()), 32'(pack_exp(3, 1, 1, 1, 0)));

        blue_up = ~blue_up;
        tick(3);
        red_up = ~red_up;
        tick(3);
        check("over_absorbs_goals", 32'(pack_act()), 32'(pack_exp(3, 1, 1, 1, 0)));

        start_btn = 1'b1;
        wait_over_clear("restart_clears_over");
        check("restart_cleared", 32'(pack_act()), 32'(pack_exp(0, 0, 0, 0, 0)));
        serve_len("restart_serve_ignores_start", 1'b1);
        start_btn = 1'b0;
        check("restart_play", 32'(pack_act()), 32'(pack_exp(0, 0, 0, 0, 1)));

        goal(1, 0, pack_exp(1, 0, 0, 0, 0));
        wait_play("play_d1");
        goal(0, 1, pack_exp(1, 1, 0, 0, 0));
        wait_play("play_d2");
        goal(1, 0, pack_exp(2, 1, 0, 0, 0));
        wait_play("play_d3");
        goal(0, 1, pack_exp(2, 2, 0, 0, 0));
        wait_play("play_d4");
        goal(1, 1, pack_exp(3, 3, 3, 1, 0));
        tick(2);
        check("draw_state", 32'(pack_act()), 32'(pack_exp(3, 3, 3, 1, 0)));

        tick(2);
        start_btn = 1'b1;
        wait_over_clear("restart2_clears_over");
        tick(1);
        start_btn = 1'b0;
        wait_play("restart2_play");

        goal(1, 0, pack_exp(1, 0, 0, 0, 0));
        wait_play("play_r1");
        goal(1, 0, pack_exp(2, 0, 0, 0, 0));
        tick(2);
        check("pre_reset_blue", 32'(blue_score), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({pack_act(), goal_pulse}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("idle_after_reset", 32'({game_initiated, game_over}), 32'd0);
        red_up = ~red_up;
        tick(3);
        check("idle_absorbs_red", 32'(red_score), 32'd0);

        tick(2);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
